// File: rtl/my_pkg.sv
// Shared defaults and types for the single-clock FIFO with a multi-cycle read.
// No logic. No latency.
// No flow control.
package my_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int FIFO_DEPTH       = 16;
    localparam int FIFO_READ_CYCLES = 4;

    // The read engine is either idle or waiting out the read latency.
    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_t;

endpackage

// File: rtl/intf_fifo.sv
// Bundle of FIFO pins with a design-side and a bench-side view.
// No logic. No latency.
// Flow control is carried by full/busy flags on the dut side.
interface intf_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input logic clk
);
    logic                       rst_n;
    logic                       push;
    logic [DATA_WIDTH-1:0]      data_in;
    logic                       pop;
    logic [DATA_WIDTH-1:0]      data_out;
    logic                       read_en;
    logic                       busy;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       underflow;

    modport dut (
        input  clk, rst_n, push, data_in, pop,
        output data_out, read_en, busy, full, empty, almost_full, count,
               overflow, underflow
    );

    modport tb (
        input  clk, data_out, read_en, busy, full, empty, almost_full, count,
               overflow, underflow,
        output rst_n, push, data_in, pop
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// Write lands at the clock edge; read data appears the cycle after rd_en.
// No backpressure; the caller guarantees legal addresses.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_dat,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_dat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: written on accepted pushes, deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Holding register: snapshots the popped entry so later writes cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_1c_w_nc_r.sv
// Single-clock FIFO whose reads complete READ_CYCLES clocks after a pop is accepted.
// read_en pulses READ_CYCLES cycles after the accepting edge; busy covers that window.
// Pushes dropped while full (overflow), pops ignored while busy or empty (underflow).
module fifo_1c_w_nc_r #(
    parameter int DATA_WIDTH  = my_pkg::DATA_WIDTH,
    parameter int DEPTH       = my_pkg::FIFO_DEPTH,
    parameter int READ_CYCLES = my_pkg::FIFO_READ_CYCLES,
    parameter int AF_THRESH   = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     read_en,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    import my_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    // WAIT spends READ_CYCLES-1 edges; the counter reaches zero on the last one.
    localparam logic [3:0] WAIT_LOAD = (READ_CYCLES > 1) ? 4'(READ_CYCLES - 2) : 4'd0;

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, empty_q, af_q;
    logic                  push_acc, pop_acc;
    rd_state_t             state_q, state_nxt;
    logic [3:0]            cnt_q, cnt_nxt;
    logic                  fire;
    logic                  read_en_q;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  ovf_q, unf_q;

    assign busy     = (state_q == RD_WAIT) || read_en_q;
    assign push_acc = push && !full_q;
    assign pop_acc  = pop && !empty_q && !busy;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  (data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr_q),
        .rd_dat  (hold_dat)
    );

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count_q;
        if (push_acc && !pop_acc) begin
            count_nxt = count_q + 1'b1;
        end else if (!push_acc && pop_acc) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // Pointers, count and level flags all move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= (AF_THRESH == 0);
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
        end
    end

    // Read engine next state: a single-cycle read never leaves IDLE.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        fire      = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (pop_acc) begin
                    if (READ_CYCLES == 1) begin
                        fire = 1'b1;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    fire      = 1'b1;
                    state_nxt = RD_IDLE;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Read engine registers; the output word is loaded on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            cnt_q      <= '0;
            read_en_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            read_en_q <= fire;
            if (fire) data_out_q <= hold_dat;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && full_q)             ovf_q <= 1'b1;
            if (pop && empty_q && !busy)    unf_q <= 1'b1;
        end
    end

    // With one-cycle reads the holding register is captured on the accepting
    // edge itself, so it already is the output word.
    assign data_out    = (READ_CYCLES == 1) ? hold_dat : data_out_q;
    assign read_en     = read_en_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_fifo_1c_w_nc_r.sv
// Directed bench: a READ_CYCLES=4 instance and a READ_CYCLES=1 instance.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Every wait on read_en is bounded.
module tb_fifo_1c_w_nc_r;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    intf_fifo #(.DATA_WIDTH(8), .DEPTH(16)) if0 (.clk(clk));
    intf_fifo #(.DATA_WIDTH(8), .DEPTH(16)) if1 (.clk(clk));

    fifo_1c_w_nc_r #(.DATA_WIDTH(8), .DEPTH(16), .READ_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(if0.rst_n), .push(if0.push), .data_in(if0.data_in),
        .pop(if0.pop), .data_out(if0.data_out), .read_en(if0.read_en),
        .busy(if0.busy), .full(if0.full), .empty(if0.empty),
        .almost_full(if0.almost_full), .count(if0.count),
        .overflow(if0.overflow), .underflow(if0.underflow)
    );

    fifo_1c_w_nc_r #(.DATA_WIDTH(8), .DEPTH(16), .READ_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(if1.rst_n), .push(if1.push), .data_in(if1.data_in),
        .pop(if1.pop), .data_out(if1.data_out), .read_en(if1.read_en),
        .busy(if1.busy), .full(if1.full), .empty(if1.empty),
        .almost_full(if1.almost_full), .count(if1.count),
        .overflow(if1.overflow), .underflow(if1.underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals0(input string tag);
        check({tag, "_cnt"},  32'(if0.count), 0);
        check({tag, "_emp"},  32'(if0.empty), 1);
        check({tag, "_full"}, 32'(if0.full), 0);
        check({tag, "_af"},   32'(if0.almost_full), 0);
        check({tag, "_busy"}, 32'(if0.busy), 0);
        check({tag, "_ren"},  32'(if0.read_en), 0);
        check({tag, "_dout"}, 32'(if0.data_out), 0);
        check({tag, "_ovf"},  32'(if0.overflow), 0);
        check({tag, "_unf"},  32'(if0.underflow), 0);
    endtask

    // Wait (bounded) for read_en on dut0, then check the delivered word.
    task automatic wait_read0(input string tag, input logic [7:0] exp);
        for (int k = 0; k < 10; k++) begin
            if (if0.read_en) break;
            tick();
        end
        check({tag, "_ren"}, 32'(if0.read_en), 1);
        check({tag, "_dat"}, 32'(if0.data_out), 32'(exp));
        tick();
    endtask

    task automatic read_one0(input logic [7:0] exp, input int exp_cnt);
        if0.pop = 1'b1;
        tick();
        if0.pop = 1'b0;
        check("rd_cnt", 32'(if0.count), 32'(exp_cnt));
        wait_read0("rd", exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        if0.rst_n = 1'b0; if0.push = 1'b0; if0.pop = 1'b0; if0.data_in = '0;
        if1.rst_n = 1'b0; if1.push = 1'b0; if1.pop = 1'b0; if1.data_in = '0;
        tick();
        reset_vals0("rst");
        check("rst1_emp", 32'(if1.empty), 1);
        check("rst1_ren", 32'(if1.read_en), 0);
        @(negedge clk);
        if0.rst_n = 1'b1;
        if1.rst_n = 1'b1;
        #4;

        // Pop on empty straight after reset: ignored, underflow set.
        if0.pop = 1'b1;
        tick();
        if0.pop = 1'b0;
        check("unf_flag", 32'(if0.underflow), 1);
        check("unf_cnt",  32'(if0.count), 0);
        check("unf_busy", 32'(if0.busy), 0);
        for (int c = 0; c < 5; c++) begin
            check("unf_noren", 32'(if0.read_en), 0);
            tick();
        end

        // Push A5 in cycle 0, pop in cycle 2: busy 3..6, read_en only in 6.
        if0.push = 1'b1; if0.data_in = 8'hA5;
        tick();
        if0.push = 1'b0;
        check("lat_cnt1", 32'(if0.count), 1);
        tick();
        if0.pop = 1'b1;
        tick();
        if0.pop = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            check("lat_busy", 32'(if0.busy), 32'(c <= 6));
            check("lat_ren",  32'(if0.read_en), 32'(c == 6));
            if (c >= 6) check("lat_dat", 32'(if0.data_out), 32'h A5);
            tick();
        end
        check("lat_emp", 32'(if0.empty), 1);

        // Fill to 16, one extra push dropped, then drain in order.
        for (int i = 0; i < 16; i++) begin
            if0.push = 1'b1; if0.data_in = 8'(i);
            tick();
            check("fill_cnt",  32'(if0.count), 32'(i + 1));
            check("fill_af",   32'(if0.almost_full), 32'(i + 1 >= 14));
            check("fill_full", 32'(if0.full), 32'(i + 1 == 16));
        end
        if0.data_in = 8'hFF;
        tick();
        if0.push = 1'b0;
        check("ovf_flag", 32'(if0.overflow), 1);
        check("ovf_cnt",  32'(if0.count), 16);
        for (int i = 0; i < 16; i++) begin
            read_one0(8'(i), 15 - i);
        end
        check("drain_emp",  32'(if0.empty), 1);
        check("drain_full", 32'(if0.full), 0);
        check("drain_af",   32'(if0.almost_full), 0);

        // Count 5, push+pop together, then a pop while busy is ignored.
        for (int i = 0; i < 5; i++) begin
            if0.push = 1'b1; if0.data_in = 8'h10 + 8'(i);
            tick();
        end
        check("c5_cnt", 32'(if0.count), 5);
        if0.data_in = 8'h20; if0.pop = 1'b1;
        tick();
        if0.push = 1'b0;
        check("pp_cnt",  32'(if0.count), 5);
        check("pp_busy", 32'(if0.busy), 1);
        tick();
        if0.pop = 1'b0;
        check("bsy_cnt", 32'(if0.count), 5);
        wait_read0("pp", 8'h10);
        read_one0(8'h11, 4);
        read_one0(8'h12, 3);
        read_one0(8'h13, 2);
        read_one0(8'h14, 1);
        read_one0(8'h20, 0);
        check("sticky_ovf", 32'(if0.overflow), 1);
        check("sticky_unf", 32'(if0.underflow), 1);

        // Reset two cycles after a pop is accepted: read aborted, entry lost.
        if0.push = 1'b1; if0.data_in = 8'h77;
        tick();
        if0.push = 1'b0;
        if0.pop = 1'b1;
        tick();
        if0.pop = 1'b0;
        check("ab_busy", 32'(if0.busy), 1);
        tick();
        if0.rst_n = 1'b0;
        #1;
        reset_vals0("abort");
        @(posedge clk);
        @(negedge clk);
        if0.rst_n = 1'b1;
        #4;
        for (int c = 0; c < 8; c++) begin
            check("ab_noren", 32'(if0.read_en), 0);
            tick();
        end
        check("ab_emp", 32'(if0.empty), 1);

        // One-cycle reads across the pointer wrap on dut1.
        if1.push = 1'b1; if1.data_in = 8'h3F;
        tick();
        for (int i = 0; i < 20; i++) begin
            check("rc1_idle_ren", 32'(if1.read_en), 0);
            if1.push = 1'b1; if1.pop = 1'b1; if1.data_in = 8'h40 + 8'(i);
            tick();
            if1.push = 1'b0; if1.pop = 1'b0;
            check("rc1_ren",  32'(if1.read_en), 1);
            check("rc1_dat",  32'(if1.data_out), 32'(8'h3F + 8'(i)));
            check("rc1_cnt",  32'(if1.count), 1);
            check("rc1_busy", 32'(if1.busy), 1);
            tick();
        end
        check("rc1_unf", 32'(if1.underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_1c_w_nc_r.md
FIFO_1C_W_NC_R -- requirements
Module: fifo_1c_w_nc_r

Interface
REQ-001 Parameter DATA_WIDTH, default my_pkg::DATA_WIDTH, word width in bits.
REQ-002 Parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 Parameter READ_CYCLES, default 4, read latency in clocks; legal 1..16.
REQ-004 Parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH.
REQ-005 clock  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 push  input  1  write request; data_in written if accepted.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 pop  input  1  read request; starts a READ_CYCLES read if accepted.
REQ-010 data_out  output  DATA_WIDTH  read data, registered, valid while read_en high, held afterwards.
REQ-011 read_en  output  1  one-cycle pulse marking data_out valid.
REQ-012 busy  output  1  read in progress; new pops ignored.
REQ-013 full / empty  output  1 each  count == DEPTH / count == 0.
REQ-014 almost_full  output  1  count >= AF_THRESH.
REQ-015 count  output  $clog2(DEPTH)+1  stored entries.
REQ-016 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 Push accepted at an edge iff push=1 and full=0 in that cycle; word written at wr_ptr, wr_ptr wraps DEPTH-1 -> 0.
REQ-018 Pop accepted iff pop=1, empty=0, busy=0; at accepting edge rd_ptr advances (wraps), count decrements, entry captured into internal holding register.
REQ-019 Read FSM: IDLE -> (pop accepted) WAIT; WAIT counts READ_CYCLES-1 further edges; at final edge data_out loaded, read_en=1 one cycle, FSM -> IDLE; READ_CYCLES=1 goes IDLE -> IDLE with read_en high the cycle after acceptance.
REQ-020 busy=1 from the cycle after acceptance until the cycle read_en is high, inclusive; a pop in the read_en cycle is not accepted (back-to-back reads spaced READ_CYCLES+1 cycles apart).
REQ-021 Pop while busy: ignored, no flag. Pop while empty and idle: ignored, underflow set.
REQ-022 Push while full: ignored, data dropped, overflow set; overflow/underflow clear only on reset.
REQ-023 Simultaneous accepted push and pop: count unchanged; both pointers advance.
REQ-024 Push when full with pop in same cycle: push rejected (full sampled pre-edge), overflow set.
REQ-025 Push and pop when empty: push accepted, pop ignored, underflow set; no bypass.
REQ-026 full, empty, almost_full, count are registered, updated at the same edge as pointers.
REQ-027 Storage not reset; read of an entry never returns a value written after its pop acceptance.

Reset
REQ-028 reset=0 asynchronously forces: pointers 0, count 0, empty 1, full 0, almost_full 0 (1 if AF_THRESH=0), busy 0, read_en 0, data_out 0, overflow 0, underflow 0, FSM IDLE.
REQ-029 Reset during WAIT aborts the read; no read_en pulse after release; popped entry is lost.
REQ-030 First accepted push/pop is the first rising edge with reset=1.

Structure
REQ-031 my_pkg holds DATA_WIDTH, FIFO_DEPTH, FIFO_READ_CYCLES defaults and rd_state_t enum {RD_IDLE, RD_WAIT}.
REQ-032 Storage in sub-module fifo_mem (one write port, one registered read port, DEPTH x DATA_WIDTH); pointers, flags and FSM in top.
REQ-033 intf_fifo gains busy, almost_full, count, overflow, underflow in its dut/tb modports.

Verification
REQ-034 DEPTH=16, RC=4: push 0xA5 in cycle 0, pop cycle 2 -> read_en high cycle 6 only, data_out=0xA5, busy cycles 3-6.
REQ-035 Push 16 words 0..15 -> full=1, count=16, almost_full from count 14; 17th push 0xFF -> dropped, overflow=1; drain -> 0..15 in order, empty=1.
REQ-036 Pop on empty after reset -> no read_en, underflow=1, count=0.
REQ-037 Count=5, push+pop same cycle -> count stays 5; pop during busy -> ignored, count unchanged.
REQ-038 Pop accepted, reset=0 two cycles later for 1 cycle -> all outputs at reset values immediately, no read_en after release.
REQ-039 RC=1: 20 push/pop cycles crossing wrap -> every read_en one cycle after acceptance, data in order.
